// File: rtl/hpdmc_ddrwr_seq.sv
// rtl/hpdmc_ddrwr_seq.sv - DDR write-burst sequencer feeding ODDR2 DQ/DM/DQS banks
module hpdmc_ddrwr_seq #(
    parameter int DQBITS       = 32,
    parameter int BURST_CYCLES = 4,
    parameter int WL           = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun,
    input  logic [2*DQBITS-1:0]     wr_data,
    input  logic [2*DQBITS/8-1:0]   wr_mask,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DQBITS-1:0]       dq_rise,
    output logic [DQBITS-1:0]       dq_fall,
    output logic [DQBITS/8-1:0]     dm_rise,
    output logic [DQBITS/8-1:0]     dm_fall,
    output logic                    dqs_rise,
    output logic                    dqs_fall,
    output logic                    dq_oe,
    output logic                    dqs_oe
);
    localparam int MW = DQBITS / 8;
    localparam logic [2:0] WL_M1     = 3'((WL > 0) ? WL - 1 : 0);
    localparam logic [2:0] LAST_BEAT = 3'(BURST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATENCY,
        S_PREAMBLE,
        S_DATA,
        S_POSTAMBLE
    } state_t;

    state_t     state, state_nx;
    logic [2:0] lat_cnt, lat_cnt_nx;
    logic [2:0] beat, beat_nx;
    logic       take, starve, accept;

    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        beat_nx    = beat;
        case (state)
            S_IDLE: begin
                if (start) begin
                    lat_cnt_nx = WL_M1;
                    beat_nx    = '0;
                    state_nx   = (WL == 0) ? S_PREAMBLE : S_LATENCY;
                end
            end
            S_LATENCY: begin
                if (lat_cnt == '0) state_nx = S_PREAMBLE;
                else               lat_cnt_nx = lat_cnt - 3'd1;
            end
            S_PREAMBLE: begin
                beat_nx  = '0;
                state_nx = S_DATA;
            end
            S_DATA: begin
                if (beat == LAST_BEAT) state_nx = S_POSTAMBLE;
                else                   beat_nx  = beat + 3'd1;
            end
            S_POSTAMBLE: state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Ready runs one cycle ahead of DATA so each word is on the pins the cycle after it is taken.
    assign wr_ready = (state == S_PREAMBLE) || ((state == S_DATA) && (beat != LAST_BEAT));
    assign take     = wr_ready && wr_valid;
    assign starve   = wr_ready && !wr_valid;
    assign accept   = (state == S_IDLE) && start;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            lat_cnt  <= '0;
            beat     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            dq_rise  <= '0;
            dq_fall  <= '0;
            dm_rise  <= '0;
            dm_fall  <= '0;
            dqs_rise <= 1'b0;
            dqs_fall <= 1'b0;
            dq_oe    <= 1'b0;
            dqs_oe   <= 1'b0;
        end else begin
            state    <= state_nx;
            lat_cnt  <= lat_cnt_nx;
            beat     <= beat_nx;
            busy     <= (state_nx != S_IDLE);
            done     <= (state_nx == S_POSTAMBLE);
            dqs_rise <= (state_nx == S_DATA);
            dqs_fall <= 1'b0;
            dq_oe    <= (state_nx == S_DATA);
            dqs_oe   <= (state_nx == S_PREAMBLE) || (state_nx == S_DATA) ||
                        (state_nx == S_POSTAMBLE);
            if (accept)      underrun <= 1'b0;
            else if (starve) underrun <= 1'b1;
            // A starved beat still goes out, fully masked, to keep DRAM timing intact.
            if (state_nx == S_DATA) begin
                dq_rise <= take ? wr_data[2*DQBITS-1:DQBITS] : '0;
                dq_fall <= take ? wr_data[DQBITS-1:0]        : '0;
                dm_rise <= take ? wr_mask[2*MW-1:MW]         : '1;
                dm_fall <= take ? wr_mask[MW-1:0]            : '1;
            end else begin
                dq_rise <= '0;
                dq_fall <= '0;
                dm_rise <= '0;
                dm_fall <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hpdmc_ddrwr_seq.sv
// tb/tb_hpdmc_ddrwr_seq.sv - self-checking bench for hpdmc_ddrwr_seq (WL=1 and WL=0 instances)
module tb_hpdmc_ddrwr_seq;
    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        rst, start, wr_valid;
    logic [63:0] wr_data;
    logic [7:0]  wr_mask;

    logic        busy_o [2], done_o [2], und_o [2], rdy_o [2];
    logic        dqsr_o [2], dqsf_o [2], dqoe_o [2], dqsoe_o [2];
    logic [31:0] dqr_o [2], dqf_o [2];
    logic [3:0]  dmr_o [2], dmf_o [2];

    int n_chk = 0, n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    hpdmc_ddrwr_seq #(.DQBITS(32), .BURST_CYCLES(BC), .WL(1)) u0 (
        .sys_clk(clk), .sys_rst(rst), .start(start), .busy(busy_o[0]), .done(done_o[0]),
        .underrun(und_o[0]), .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid),
        .wr_ready(rdy_o[0]), .dq_rise(dqr_o[0]), .dq_fall(dqf_o[0]), .dm_rise(dmr_o[0]),
        .dm_fall(dmf_o[0]), .dqs_rise(dqsr_o[0]), .dqs_fall(dqsf_o[0]), .dq_oe(dqoe_o[0]),
        .dqs_oe(dqsoe_o[0]));

    hpdmc_ddrwr_seq #(.DQBITS(32), .BURST_CYCLES(BC), .WL(0)) u1 (
        .sys_clk(clk), .sys_rst(rst), .start(start), .busy(busy_o[1]), .done(done_o[1]),
        .underrun(und_o[1]), .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid),
        .wr_ready(rdy_o[1]), .dq_rise(dqr_o[1]), .dq_fall(dqf_o[1]), .dm_rise(dmr_o[1]),
        .dm_fall(dmf_o[1]), .dqs_rise(dqsr_o[1]), .dqs_fall(dqsf_o[1]), .dq_oe(dqoe_o[1]),
        .dqs_oe(dqsoe_o[1]));

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[u%0d] at %0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Model: a burst is a timeline of cycles k=1..WL+BC+2 after the accepted start.
    bit          m_act [2];
    int          m_k [2];
    bit          m_und [2];
    bit          m_acc [2];
    logic [63:0] m_data [2];
    logic [7:0]  m_mask [2];
    int          e_wl, e_beat;
    bit          e_pre, e_dat, e_post, e_rdy;

    initial for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_k[i] = 0; m_und[i] = 0; m_acc[i] = 0; m_data[i] = '0; m_mask[i] = '0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                e_wl   = (i == 0) ? 1 : 0;
                e_pre  = m_act[i] && (m_k[i] == e_wl + 1);
                e_dat  = m_act[i] && (m_k[i] >= e_wl + 2) && (m_k[i] <= e_wl + BC + 1);
                e_post = m_act[i] && (m_k[i] == e_wl + BC + 2);
                e_beat = m_k[i] - e_wl - 2;
                e_rdy  = e_pre || (e_dat && e_beat < BC - 1);
                chk(i, "busy",     32'(busy_o[i]),  32'(m_act[i]));
                chk(i, "done",     32'(done_o[i]),  32'(e_post));
                chk(i, "underrun", 32'(und_o[i]),   32'(m_und[i]));
                chk(i, "wr_ready", 32'(rdy_o[i]),   32'(e_rdy));
                chk(i, "dqs_oe",   32'(dqsoe_o[i]), 32'(e_pre || e_dat || e_post));
                chk(i, "dq_oe",    32'(dqoe_o[i]),  32'(e_dat));
                chk(i, "dqs_rise", 32'(dqsr_o[i]),  32'(e_dat));
                chk(i, "dqs_fall", 32'(dqsf_o[i]),  32'd0);
                chk(i, "dq_rise",  dqr_o[i], !e_dat ? 32'd0 : (m_acc[i] ? m_data[i][63:32] : 32'd0));
                chk(i, "dq_fall",  dqf_o[i], !e_dat ? 32'd0 : (m_acc[i] ? m_data[i][31:0]  : 32'd0));
                chk(i, "dm_rise",  32'(dmr_o[i]), !e_dat ? 32'd0 : (m_acc[i] ? 32'(m_mask[i][7:4]) : 32'hF));
                chk(i, "dm_fall",  32'(dmf_o[i]), !e_dat ? 32'd0 : (m_acc[i] ? 32'(m_mask[i][3:0]) : 32'hF));
                if (rst) begin
                    m_act[i] = 0; m_und[i] = 0; m_acc[i] = 0;
                end else begin
                    m_acc[i]  = e_rdy && wr_valid;
                    m_data[i] = wr_data;
                    m_mask[i] = wr_mask;
                    if (e_rdy && !wr_valid) m_und[i] = 1;
                    if (m_act[i]) begin
                        m_k[i]++;
                        if (m_k[i] > e_wl + BC + 2) m_act[i] = 0;
                    end else if (start) begin
                        m_act[i] = 1; m_k[i] = 1; m_und[i] = 0;
                    end
                end
            end
        end
    end

    // Source: word index advances on each acceptance by the WL=1 instance.
    int idx, rcnt, dcnt;
    bit drop;

    task automatic step();
        bit acc, rdy;
        rdy = rdy_o[0];
        acc = rdy && wr_valid;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (acc) idx++;
        if (rdy) rcnt++;
        if (done_o[0]) dcnt++;
        wr_data  = {32'hA0 + 32'(idx), 32'hB0 + 32'(idx)};
        wr_valid = !(drop && rdy_o[0] && rcnt == 1);
    endtask

    task automatic begin_burst();
        idx = 0; rcnt = 0; dcnt = 0;
        wr_data = {32'hA0, 32'hB0};
        start = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_valid = 1'b1; wr_mask = 8'h00; drop = 0;
        idx = 0; rcnt = 0; dcnt = 0;
        wr_data = {32'hA0, 32'hB0};
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk(0, "rst_busy",   32'(busy_o[0]),  0);
        chk(0, "rst_dqs_oe", 32'(dqsoe_o[0]), 0);
        chk(0, "rst_dq",     dqr_o[0],        0);
        chk(1, "rst_dm",     32'(dmf_o[1]),   0);
        @(posedge clk); #1 rst = 1'b0;
        steps(2);

        // Basic burst, WL=1 on u0 and WL=0 on u1
        begin_burst();
        step();
        chk(0, "t1_busy", 32'(busy_o[0]), 1);
        chk(1, "t1_pre_dqs_oe", 32'(dqsoe_o[1]), 1);
        step();
        chk(0, "t2_ready", 32'(rdy_o[0]), 1);
        chk(0, "t2_pre_dqs_oe", 32'(dqsoe_o[0]), 1);
        chk(0, "t2_pre_dq_oe", 32'(dqoe_o[0]), 0);
        chk(1, "t2_dq_oe", 32'(dqoe_o[1]), 1);
        step();
        chk(0, "t3_dq_rise", dqr_o[0], 32'hA0);
        chk(0, "t3_dq_fall", dqf_o[0], 32'hB0);
        steps(3);
        chk(0, "t6_dq_rise", dqr_o[0], 32'hA3);
        chk(0, "t6_dq_fall", dqf_o[0], 32'hB3);
        chk(1, "t6_done", 32'(done_o[1]), 1);
        step();
        chk(0, "t7_done", 32'(done_o[0]), 1);
        chk(0, "t7_dq_rise", dqr_o[0], 0);
        step();
        chk(0, "t8_busy", 32'(busy_o[0]), 0);
        steps(3);

        // Underrun on the second ready cycle
        drop = 1;
        begin_burst();
        steps(4);
        chk(0, "ur_t4_dq_rise", dqr_o[0], 0);
        chk(0, "ur_t4_dm_rise", 32'(dmr_o[0]), 32'hF);
        chk(0, "ur_t4_dm_fall", 32'(dmf_o[0]), 32'hF);
        step();
        chk(0, "ur_t5_dq_rise", dqr_o[0], 32'hA1);
        steps(2);
        chk(0, "ur_t7_done", 32'(done_o[0]), 1);
        step();
        chk(0, "ur_t8_flag", 32'(und_o[0]), 1);
        drop = 0;
        steps(2);
        begin_burst();
        step();
        chk(0, "ur_cleared", 32'(und_o[0]), 0);
        steps(9);

        // start pulses inside the burst and at POSTAMBLE are ignored
        begin_burst();
        steps(3);
        start = 1'b1;
        steps(4);
        start = 1'b1;
        steps(5);
        chk(0, "ign_done_count", 32'(dcnt), 1);
        chk(0, "ign_idle", 32'(busy_o[0]), 0);
        steps(6);

        // Reset in DATA beat 2
        begin_burst();
        steps(5);
        rst = 1'b1;
        step();
        chk(0, "rst_mid_busy", 32'(busy_o[0]), 0);
        chk(0, "rst_mid_dqs_oe", 32'(dqsoe_o[0]), 0);
        chk(0, "rst_mid_dq_oe", 32'(dqoe_o[0]), 0);
        chk(0, "rst_mid_dq", dqr_o[0], 0);
        rst = 1'b0;
        steps(2);
        begin_burst();
        steps(3);
        chk(0, "post_rst_t3_dq", dqr_o[0], 32'hA0);
        steps(4);
        chk(0, "post_rst_done", 32'(done_o[0]), 1);
        steps(3);

        // Constant mask 0x0F
        wr_mask = 8'h0F;
        begin_burst();
        steps(2);
        chk(0, "mk_t2_dqs_rise", 32'(dqsr_o[0]), 0);
        step();
        chk(0, "mk_t3_dm_rise", 32'(dmr_o[0]), 0);
        chk(0, "mk_t3_dm_fall", 32'(dmf_o[0]), 32'hF);
        chk(0, "mk_t3_dqs_rise", 32'(dqsr_o[0]), 1);
        steps(4);
        chk(0, "mk_t7_dqs_rise", 32'(dqsr_o[0]), 0);
        chk(0, "mk_t7_dqs_oe", 32'(dqsoe_o[0]), 1);
        steps(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hpdmc_ddrwr_seq.md
Name: hpdmc_ddrwr_seq

Overview:
- Write-direction datapath sequencer for the HPDMC DDR controller. It is the transmit counterpart of the IDDR2 read capture path.
- On each write command it pulls one burst of 2×DQBITS-bit words from the write data source over a ready/valid handshake.
- It registers the rising-edge and falling-edge halves of each word, plus byte masks, for the external ODDR2 banks.
- It generates the DQ and DQS output enables and the DQS pattern, including preamble and postamble.

Parameters:
- DQBITS, 32, DRAM data bus width. Legal values are 16 or 32.
- BURST_CYCLES, 4, sys_clk cycles of data per burst. Each cycle carries two DDR beats. Legal range is 1..8.
- WL, 1, sys_clk cycles from start acceptance to the preamble. Legal range is 0..7.

Ports:
- sys_clk  in  1  system clock. It also drives the ODDR2 C0 input; C1 is its inverse.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  pulse marking that a WRITE command was issued this cycle.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse during the POSTAMBLE cycle.
- underrun  out  1  sticky flag: the source failed to supply a word. Cleared when start is accepted.
- wr_data  in  2*DQBITS  word from the source. Upper half is the rising beat, lower half is the falling beat.
- wr_mask  in  2*DQBITS/8  byte masks, 1 = masked. Upper half applies to the rising beat.
- wr_valid  in  1  source has a word.
- wr_ready  out  1  sequencer consumes the word this cycle if wr_valid is high.
- dq_rise  out  DQBITS  to ODDR2 D0 (DQ).
- dq_fall  out  DQBITS  to ODDR2 D1 (DQ).
- dm_rise  out  DQBITS/8  to ODDR2 D0 (DM).
- dm_fall  out  DQBITS/8  to ODDR2 D1 (DM).
- dqs_rise  out  1  to ODDR2 D0 (DQS).
- dqs_fall  out  1  to ODDR2 D1 (DQS).
- dq_oe  out  1  DQ/DM tristate enable. 1 = drive.
- dqs_oe  out  1  DQS tristate enable. 1 = drive.

Behaviour:
- All outputs except wr_ready are registered. wr_ready is combinational from state and beat counter.
- Reset values are 0 for: busy, done, underrun, wr_ready, dq_*, dm_*, dqs_*, dq_oe, dqs_oe. State resets to IDLE and counters reset to 0.
- States: IDLE → LATENCY → PREAMBLE → DATA → POSTAMBLE → IDLE.
- IDLE:
  - start=1 → LATENCY, or → PREAMBLE if WL=0.
  - Latency counter loads WL-1. underrun clears.
  - start is ignored in every other state, including POSTAMBLE. It is not queued.
- LATENCY:
  - Counter decrements. When it reaches 0 → PREAMBLE.
  - Occupies exactly WL cycles.
  - All enables are 0.
- PREAMBLE (1 cycle):
  - dqs_oe=1, dqs_rise=0, dqs_fall=0, dq_oe=0.
  - Beat counter = 0.
- DATA (BURST_CYCLES cycles):
  - dqs_oe=1, dqs_rise=1, dqs_fall=0, dq_oe=1.
  - dq_* and dm_* show the word captured in the previous cycle.
  - Beat counter increments. At BURST_CYCLES-1 → POSTAMBLE.
- POSTAMBLE (1 cycle):
  - dqs_oe=1, dqs=0/0, dq_oe=0.
  - done=1.
  - Next state is IDLE.
- Look-ahead handshake:
  - wr_ready=1 in PREAMBLE and in DATA beats 0..BURST_CYCLES-2. This gives exactly BURST_CYCLES ready cycles per burst.
  - A word accepted with wr_ready & wr_valid appears on dq/dm in the following cycle.
- Underrun:
  - If wr_ready=1 and wr_valid=0, the next DATA cycle drives dq_* = 0 and dm_* = all ones (fully masked). underrun is set.
  - DRAM timing is fixed, so the burst still completes and the beat counter is unaffected.
- Outside DATA, dq_* and dm_* hold 0.
- sys_rst asserted mid-burst:
  - Next edge returns to IDLE and all outputs go to reset values; the enables drop immediately.
  - No done pulse, and the partial burst is abandoned.
- Total busy duration per burst = WL + BURST_CYCLES + 2 cycles.

Test Plan:
- Default params, start at T0, source always valid with words 0xA0..A3_B0..B3:
  - busy T1..T7; preamble T2; DATA T3..T6 with dq_rise=0xA0,A1,A2,A3 and dq_fall=0xB0..B3; dm=0.
  - POSTAMBLE T7 with done=1; 4 wr_ready cycles T2..T5.
- WL=0: start at T0 → PREAMBLE at T1, DATA T2..T5, done at T6.
- wr_valid=0 only during the second ready cycle:
  - Beat 1 drives dq=0 and dm_rise=dm_fall=4'hF; underrun=1.
  - The other beats are correct and the burst length is unchanged.
  - underrun clears on the next accepted start.
- start pulses at T3 and at the POSTAMBLE cycle → both ignored; exactly one done; IDLE afterward.
- sys_rst asserted in DATA beat 2 → next cycle all outputs are 0 and the state is IDLE. A following start produces a clean full burst.
- wr_mask=8'h0F with every word:
  - dm_rise=0 and dm_fall=4'hF on every DATA cycle.
  - dqs_rise/dqs_fall are 1/0 in DATA and 0/0 in PREAMBLE and POSTAMBLE.
